// File: rtl/alu_wb.sv
// alu_wb: writeback stage behind the ALU.
// Merges ALU flags into the architectural flags under a per-flag mask.
// Queues register-file writes in a 2-entry FIFO that drains through an
// arbitrated write port. Exposes pending-write and forwarding information to decode.
module alu_wb #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREG  = 4,
    localparam int unsigned RW   = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_dout,
    input  logic [3:0]       in_fout,
    input  logic [3:0]       in_fmask,
    input  logic             in_wen,
    input  logic [RW-1:0]    in_rd,
    output logic [3:0]       flags,
    output logic             rf_req,
    input  logic             rf_gnt,
    output logic [RW-1:0]    rf_waddr,
    output logic [WIDTH-1:0] rf_wdata,
    output logic [NREG-1:0]  pend_mask,
    output logic             fwd_valid,
    output logic [RW-1:0]    fwd_rd,
    output logic [WIDTH-1:0] fwd_data
);

    logic [3:0]       flags_q, flags_d;
    logic [1:0]       count_q, count_d;
    logic             wptr_q, wptr_d;
    logic             rptr_q, rptr_d;
    logic [RW-1:0]    rd_q   [2];
    logic [WIDTH-1:0] data_q [2];
    logic             acc, push, pop;
    logic             young_idx;
    logic [1:0]       ent_vld;

    assign in_ready  = (count_q != 2'd2);
    assign rf_req    = (count_q != 2'd0);
    assign acc       = in_valid && in_ready;
    assign push      = acc && in_wen;
    // A grant while empty is ignored because rf_req is low.
    assign pop       = rf_req && rf_gnt;
    assign young_idx = ~wptr_q;

    assign flags     = flags_q;
    assign rf_waddr  = rd_q[rptr_q];
    assign rf_wdata  = data_q[rptr_q];
    assign fwd_valid = rf_req;
    // Forwarding outputs read as zero when nothing is buffered.
    assign fwd_rd    = fwd_valid ? rd_q[young_idx] : '0;
    assign fwd_data  = fwd_valid ? data_q[young_idx] : '0;

    // Next-state for flags, pointers and occupancy.
    always_comb begin
        flags_d = flags_q;
        count_d = count_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (acc) begin
            flags_d = (flags_q & ~in_fmask) | (in_fout & in_fmask);
        end
        if (push) begin
            wptr_d = ~wptr_q;
        end
        if (pop) begin
            rptr_d = ~rptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Which storage slots currently hold a buffered write.
    always_comb begin
        ent_vld = 2'b00;
        if (count_q == 2'd2) begin
            ent_vld = 2'b11;
        end else if (count_q == 2'd1) begin
            ent_vld[rptr_q] = 1'b1;
        end
    end

    // OR-decode of buffered destinations; duplicates keep the bit set.
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < 2; i++) begin
            if (ent_vld[i]) begin
                pend_mask[rd_q[i]] = 1'b1;
            end
        end
    end

    // State registers; reset discards any buffered writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
            count_q <= 2'd0;
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            flags_q <= flags_d;
            count_q <= count_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            if (push) begin
                rd_q[wptr_q]   <= in_rd;
                data_q[wptr_q] <= in_dout;
            end
        end
    end

endmodule

// File: tb/tb_alu_wb.sv
// tb_alu_wb: scoreboard bench for alu_wb. Stimulus pushes expected writes
// into a queue on acceptance; a negedge monitor checks outputs and pops on grant.
module tb_alu_wb;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned NREG  = 4;
    localparam int unsigned RW    = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_dout;
    logic [3:0]       in_fout;
    logic [3:0]       in_fmask;
    logic             in_wen;
    logic [RW-1:0]    in_rd;
    logic [3:0]       flags;
    logic             rf_req;
    logic             rf_gnt;
    logic [RW-1:0]    rf_waddr;
    logic [WIDTH-1:0] rf_wdata;
    logic [NREG-1:0]  pend_mask;
    logic             fwd_valid;
    logic [RW-1:0]    fwd_rd;
    logic [WIDTH-1:0] fwd_data;

    always #5 clk = ~clk;

    alu_wb #(.WIDTH(WIDTH), .NREG(NREG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dout   (in_dout),
        .in_fout   (in_fout),
        .in_fmask  (in_fmask),
        .in_wen    (in_wen),
        .in_rd     (in_rd),
        .flags     (flags),
        .rf_req    (rf_req),
        .rf_gnt    (rf_gnt),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .pend_mask (pend_mask),
        .fwd_valid (fwd_valid),
        .fwd_rd    (fwd_rd),
        .fwd_data  (fwd_data)
    );

    typedef struct packed {
        logic [RW-1:0]    rd;
        logic [WIDTH-1:0] data;
    } ent_t;

    // Writes accepted but not yet granted, oldest first.
    ent_t       exp_q[$];
    logic [3:0] model_flags = 4'b0000;
    logic       exp_ready = 1'b1;
    int         checks = 0;
    int         errors = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: compare every visible output against the model, retire on grant.
    always @(negedge clk) begin : monitor
        logic [NREG-1:0] pm;
        ent_t            head;
        ent_t            young;
        if (!rst_n) begin
            exp_ready = 1'b1;
        end else begin
            pm = '0;
            foreach (exp_q[i]) pm[exp_q[i].rd] = 1'b1;
            chk("in_ready", 32'(in_ready), 32'(exp_q.size() != 2));
            chk("rf_req", 32'(rf_req), 32'(exp_q.size() != 0));
            chk("fwd_valid", 32'(fwd_valid), 32'(exp_q.size() != 0));
            chk("flags", 32'(flags), 32'(model_flags));
            chk("pend_mask", 32'(pend_mask), 32'(pm));
            if (exp_q.size() != 0) begin
                head  = exp_q[0];
                young = exp_q[exp_q.size() - 1];
                chk("rf_waddr", 32'(rf_waddr), 32'(head.rd));
                chk("rf_wdata", 32'(rf_wdata), 32'(head.data));
                chk("fwd_rd", 32'(fwd_rd), 32'(young.rd));
                chk("fwd_data", 32'(fwd_data), 32'(young.data));
            end
            exp_ready = (exp_q.size() != 2);
            if (exp_q.size() != 0 && rf_gnt) begin
                void'(exp_q.pop_front());
            end
        end
    end

    // Drive one cycle of inputs; book the op into the model if it was accepted.
    task automatic step(input logic v, input logic w, input logic [RW-1:0] rd,
                        input logic [WIDTH-1:0] d, input logic [3:0] fo,
                        input logic [3:0] fm, input logic g, output logic accepted);
        ent_t e;
        in_valid = v;
        in_wen   = w;
        in_rd    = rd;
        in_dout  = d;
        in_fout  = fo;
        in_fmask = fm;
        rf_gnt   = g;
        @(posedge clk);
        accepted = rst_n && v && exp_ready;
        if (accepted) begin
            model_flags = (model_flags & ~fm) | (fo & fm);
            if (w) begin
                e.rd   = rd;
                e.data = d;
                exp_q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic idle(input logic g);
        logic a;
        step(1'b0, 1'b0, '0, '0, 4'b0000, 4'b0000, g, a);
    endtask

    // Hold an op until it is accepted, within a bounded number of cycles.
    task automatic issue(input logic w, input logic [RW-1:0] rd, input logic [WIDTH-1:0] d,
                         input logic [3:0] fo, input logic [3:0] fm, input logic g);
        logic a;
        a = 1'b0;
        for (int i = 0; i < 8 && !a; i++) begin
            step(1'b1, w, rd, d, fo, fm, g, a);
        end
        chk("issue_accept", 32'(a), 32'd1);
    endtask

    initial begin
        logic a;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_wen   = 1'b0;
        in_rd    = '0;
        in_dout  = '0;
        in_fout  = 4'b0000;
        in_fmask = 4'b0000;
        rf_gnt   = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_rf_req", 32'(rf_req), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        chk("rst_pend", 32'(pend_mask), 32'd0);
        chk("rst_fwd_valid", 32'(fwd_valid), 32'd0);
        chk("rst_fwd_rd", 32'(fwd_rd), 32'd0);
        chk("rst_fwd_data", 32'(fwd_data), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single op with grant held high.
        step(1'b1, 1'b1, 2'd2, 8'hA5, 4'b1001, 4'b1111, 1'b1, a);
        chk("single_flags", 32'(flags), 32'h9);
        chk("single_req", 32'(rf_req), 32'd1);
        chk("single_waddr", 32'(rf_waddr), 32'd2);
        chk("single_wdata", 32'(rf_wdata), 32'hA5);
        chk("single_pend", 32'(pend_mask), 32'h4);
        idle(1'b1);
        chk("single_pend_clr", 32'(pend_mask), 32'd0);
        chk("single_req_clr", 32'(rf_req), 32'd0);

        // Masked flag update via flag-only ops.
        issue(1'b0, 2'd0, 8'h00, 4'b1111, 4'b1111, 1'b1);
        issue(1'b0, 2'd0, 8'h00, 4'b0000, 4'b0010, 1'b1);
        chk("masked_flags", 32'(flags), 32'hD);
        chk("flag_only_nopush", 32'(rf_req), 32'd0);

        // Backpressure: third op stalls until a grant frees a slot.
        step(1'b1, 1'b1, 2'd0, 8'h10, 4'b0000, 4'b0000, 1'b0, a);
        step(1'b1, 1'b1, 2'd1, 8'h21, 4'b0000, 4'b0000, 1'b0, a);
        step(1'b1, 1'b1, 2'd3, 8'h33, 4'b0000, 4'b0000, 1'b0, a);
        chk("bp_third_stall", 32'(a), 32'd0);
        chk("bp_ready", 32'(in_ready), 32'd0);
        chk("bp_pend", 32'(pend_mask), 32'h3);
        chk("bp_fwd_rd", 32'(fwd_rd), 32'd1);
        issue(1'b1, 2'd3, 8'h33, 4'b0000, 4'b0000, 1'b1);
        repeat (3) idle(1'b1);

        // Continuous ops with grant high: occupancy stays at one across wrap.
        for (int i = 0; i < 8; i++) begin
            issue(1'b1, RW'(i), WIDTH'(8'h40 + i), 4'(i), 4'b0101, 1'b1);
            chk("stream_ready", 32'(in_ready), 32'd1);
        end
        repeat (2) idle(1'b1);

        // Two writes to the same register.
        issue(1'b1, 2'd1, 8'h11, 4'b0000, 4'b0000, 1'b0);
        issue(1'b1, 2'd1, 8'h22, 4'b0000, 4'b0000, 1'b0);
        chk("same_fwd_data", 32'(fwd_data), 32'h22);
        chk("same_pend", 32'(pend_mask), 32'h2);
        idle(1'b1);
        chk("same_pend_hold", 32'(pend_mask), 32'h2);
        idle(1'b1);
        chk("same_pend_clr", 32'(pend_mask), 32'd0);

        // Asynchronous reset with two entries buffered.
        issue(1'b1, 2'd2, 8'h33, 4'b1010, 4'b1111, 1'b0);
        issue(1'b1, 2'd3, 8'h44, 4'b1010, 4'b1111, 1'b0);
        #2 rst_n = 1'b0;
        exp_q.delete();
        model_flags = 4'b0000;
        #1;
        chk("arst_req", 32'(rf_req), 32'd0);
        chk("arst_pend", 32'(pend_mask), 32'd0);
        chk("arst_flags", 32'(flags), 32'd0);
        chk("arst_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_wen   = 1'b1;
        in_fout  = 4'b1111;
        in_fmask = 4'b1111;
        rf_gnt   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("arst_hold_pend", 32'(pend_mask), 32'd0);
        chk("arst_hold_flags", 32'(flags), 32'd0);
        in_valid = 1'b0;
        in_wen   = 1'b0;
        rst_n    = 1'b1;
        repeat (4) idle(1'b1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 RW'($urandom_range(0, NREG - 1)), WIDTH'($urandom),
                 4'($urandom), 4'($urandom), $urandom_range(0, 2) != 0, a);
        end

        // Drain with a bounded budget.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) idle(1'b1);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        idle(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
